dfdd_interface: RTL and testbench
=================================

# dfdd_interface

Pixel-stream framing and collection block at the boundary of the dual-scale DFDD (depth-from-defocus) pipeline. It registers two parallel FP16 image streams, tags every pixel with its column/row position and frame markers, and forwards them to the processing core. It also registers the single result stream coming back from the core and reports when a full result frame has been collected.

## Interface
Parameters:
- EXP_WIDTH, 5, exponent bits of the floating-point pixel.
- FRAC_WIDTH, 10, fraction bits; FP_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH (16).
- IMAGE_WIDTH, 400, pixels per line.
- IMAGE_HEIGHT, 400, lines per frame.
- CW = $clog2(IMAGE_WIDTH) and RW = $clog2(IMAGE_HEIGHT) are derived localparams, not overridable.

Ports (reset is synchronous and active-low; clock is clk_i, reset is rst_i):
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous, active-low reset.
- valid_i  in  1  input pixel pair valid; no backpressure.
- data_0_i  in  FP_WIDTH  pixel of image 0.
- data_1_i  in  FP_WIDTH  pixel of image 1.
- valid_o  out  1  registered pixel pair valid.
- data_0_o, data_1_o  out  FP_WIDTH  registered pixels.
- col_o  out  CW  column of the current output pixel.
- row_o  out  RW  row of the current output pixel.
- sof_o  out  1  high with pixel (0,0).
- eol_o  out  1  high with column IMAGE_WIDTH-1.
- eof_o  out  1  high with the last pixel of the frame.
- result_valid_i  in  1  result pixel valid from the core.
- result_i  in  FP_WIDTH  result pixel.
- result_valid_o, result_o  out  1 / FP_WIDTH  registered result.
- result_col_o, result_row_o  out  CW / RW  result pixel position.
- frame_done_o  out  1  one-cycle pulse after the last result pixel of a frame.
- frame_count_o  out  16  number of completed result frames; wraps at 2^16.

## Operation
- Input path: on each cycle with valid_i=1, register data_0_i and data_1_i and emit them with valid_o=1 and the current input counter values.
- Input column counter: increments per valid pixel; wraps IMAGE_WIDTH-1→0 and then increments the row counter.
- Input row counter: wraps IMAGE_HEIGHT-1→0, which starts a new frame.
- Cycles with valid_i=0: valid_o=0; data outputs hold their previous value; counters hold.
- Result path: uses independent counters with identical wrap rules. On the last result pixel (IMAGE_WIDTH-1, IMAGE_HEIGHT-1), frame_done_o pulses and frame_count_o increments.
- The two paths are fully independent. Simultaneous valid_i and result_valid_i are both processed in the same cycle.
- Data is passed bit-exact. No arithmetic is performed on pixel values.

## Timing
- Latency is 1 cycle on both paths: the input on cycle n appears on the outputs at cycle n+1.
- Throughput is 1 pixel per cycle on each path. Gaps of any length are allowed.
- frame_done_o asserts in the same cycle as result_valid_o for the last result pixel.
- Reset (rst_i=0 at a clock edge) clears the following to 0: all counters, valid_o, result_valid_o, sof_o, eol_o, eof_o, frame_done_o, frame_count_o, and data outputs.
- Reset mid-frame discards the partial frame. The next valid pixel is treated as (0,0).
- Inputs presented while in reset are ignored.

## Configuration
- DFDD_INF_NAN_CHECK_EN defined:
  - Adds output nan_err_o (1 bit, sticky, cleared only by reset).
  - nan_err_o sets one cycle after any valid input or result pixel whose exponent field is all ones (NaN or Inf).
- DFDD_INF_NAN_CHECK_EN undefined: the port and its logic are absent.

## Structure
- Shared package dfdd_pkg holds:
  - FP16 constants (EXP_WIDTH, FRAC_WIDTH, FP_WIDTH).
  - Default IMAGE_WIDTH and IMAGE_HEIGHT.
  - A pixel position typedef {col, row}.
- One sub-module, dfdd_frame_counter, is instantiated twice (input path and result path). It provides col/row counting plus sof/eol/eof generation.

## Test plan
- Reset, then 1 valid pixel: data_0_i=16'h3C00, data_1_i=16'h4000 → next cycle valid_o=1, data_0_o=16'h3C00, data_1_o=16'h4000, col_o=0, row_o=0, sof_o=1.
- Full line of 400 pixels → 400th output has col_o=399 and eol_o=1; the next pixel has col_o=0, row_o=1.
- Full 400×400 frame with random gaps on valid_i → eof_o is high exactly once, on pixel 160000. The next pixel has sof_o=1.
- 160000 result pixels → frame_done_o pulses once with (399,399) and frame_count_o=1. A second frame gives frame_count_o=2.
- Reset asserted after 1000 pixels → all outputs 0. The next valid pixel reports (0,0) with sof_o=1.
- With DFDD_INF_NAN_CHECK_EN defined, input 16'h7E00 → nan_err_o=1 one cycle later and it stays 1 until reset.

Source files
------------

// File: rtl/dfdd_pkg.sv
// dfdd_pkg: shared constants and types for the DFDD pixel-stream boundary.
//   - FP16 field widths (EXP_WIDTH, FRAC_WIDTH, FP_WIDTH)
//   - Default frame geometry (IMAGE_WIDTH_DEF x IMAGE_HEIGHT_DEF)
//   - pix_pos_t: pixel position {col, row} sized for the default geometry
package dfdd_pkg;

  localparam int unsigned EXP_WIDTH  = 5;
  localparam int unsigned FRAC_WIDTH = 10;
  localparam int unsigned FP_WIDTH   = 1 + EXP_WIDTH + FRAC_WIDTH;

  localparam int unsigned IMAGE_WIDTH_DEF  = 400;
  localparam int unsigned IMAGE_HEIGHT_DEF = 400;

  localparam int unsigned POS_CW = $clog2(IMAGE_WIDTH_DEF);
  localparam int unsigned POS_RW = $clog2(IMAGE_HEIGHT_DEF);

  typedef struct packed {
    logic [POS_CW-1:0] col;
    logic [POS_RW-1:0] row;
  } pix_pos_t;

endpackage

// File: rtl/dfdd_frame_counter.sv
// dfdd_frame_counter: column/row position counter for one pixel stream.
// The outputs describe the pixel being accepted this cycle (unregistered);
// the counters advance on every cycle with i_valid=1.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-low reset, returns the position to (0,0)
//   i_valid  a pixel is accepted this cycle
//   o_col    column of the pixel accepted this cycle
//   o_row    row of the pixel accepted this cycle
//   o_sof    position is (0,0)
//   o_eol    position is the last column
//   o_eof    position is the last column of the last row
module dfdd_frame_counter
  import dfdd_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
  parameter int unsigned IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
  localparam int unsigned CW = $clog2(IMAGE_WIDTH),
  localparam int unsigned RW = $clog2(IMAGE_HEIGHT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_valid,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_eof
);

  localparam logic [CW-1:0] ColLast = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMAGE_HEIGHT - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_last_col;
  logic          w_last_row;

  assign w_last_col = (r_col == ColLast);
  assign w_last_row = (r_row == RowLast);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_valid) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col = r_col;
  assign o_row = r_row;
  assign o_sof = (r_col == '0) && (r_row == '0);
  assign o_eol = w_last_col;
  assign o_eof = w_last_col && w_last_row;

endmodule

// File: rtl/dfdd_interface.sv
// dfdd_interface: framing of two FP16 input image streams and collection of
// the single result stream of the dual-scale DFDD core. Both paths have one
// cycle of latency and run independently; pixels are passed bit-exact.
// Optional feature macro: DFDD_INF_NAN_CHECK_EN adds the sticky nan_err_o flag.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-low reset
//   valid_i, data_0_i, data_1_i       input pixel pair
//   valid_o, data_0_o, data_1_o       registered pixel pair
//   col_o, row_o, sof_o, eol_o, eof_o position and frame markers of output pair
//   result_valid_i, result_i          result pixel from the core
//   result_valid_o, result_o          registered result pixel
//   result_col_o, result_row_o        result pixel position
//   frame_done_o                      pulse with the last result pixel of a frame
//   frame_count_o                     completed result frames (wraps)
//   nan_err_o                         (macro only) sticky Inf/NaN seen
module dfdd_interface
  import dfdd_pkg::*;
#(
  parameter int unsigned EXP_WIDTH    = dfdd_pkg::EXP_WIDTH,
  parameter int unsigned FRAC_WIDTH   = dfdd_pkg::FRAC_WIDTH,
  parameter int unsigned IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
  parameter int unsigned IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
  localparam int unsigned FP_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int unsigned CW = $clog2(IMAGE_WIDTH),
  localparam int unsigned RW = $clog2(IMAGE_HEIGHT)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [FP_WIDTH-1:0] data_0_i,
  input  logic [FP_WIDTH-1:0] data_1_i,
  output logic                valid_o,
  output logic [FP_WIDTH-1:0] data_0_o,
  output logic [FP_WIDTH-1:0] data_1_o,
  output logic [CW-1:0]       col_o,
  output logic [RW-1:0]       row_o,
  output logic                sof_o,
  output logic                eol_o,
  output logic                eof_o,
  input  logic                result_valid_i,
  input  logic [FP_WIDTH-1:0] result_i,
  output logic                result_valid_o,
  output logic [FP_WIDTH-1:0] result_o,
  output logic [CW-1:0]       result_col_o,
  output logic [RW-1:0]       result_row_o,
  output logic                frame_done_o,
  output logic [15:0]         frame_count_o
`ifdef DFDD_INF_NAN_CHECK_EN
  ,
  output logic                nan_err_o
`endif
);

  logic [CW-1:0] w_in_col;
  logic [RW-1:0] w_in_row;
  logic          w_in_sof;
  logic          w_in_eol;
  logic          w_in_eof;

  logic [CW-1:0] w_res_col;
  logic [RW-1:0] w_res_row;
  logic          w_res_sof;
  logic          w_res_eol;
  logic          w_res_eof;

  // Result-side sof/eol are not exported.
  logic          w_unused_res_flags;
  assign w_unused_res_flags = w_res_sof ^ w_res_eol;

  dfdd_frame_counter #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT)
  ) u_in_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_valid(valid_i),
    .o_col  (w_in_col),
    .o_row  (w_in_row),
    .o_sof  (w_in_sof),
    .o_eol  (w_in_eol),
    .o_eof  (w_in_eof)
  );

  dfdd_frame_counter #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT)
  ) u_res_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_valid(result_valid_i),
    .o_col  (w_res_col),
    .o_row  (w_res_row),
    .o_sof  (w_res_sof),
    .o_eol  (w_res_eol),
    .o_eof  (w_res_eof)
  );

  // Input path: data and position hold across gaps, markers only flag valid pixels.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_o  <= 1'b0;
      data_0_o <= '0;
      data_1_o <= '0;
      col_o    <= '0;
      row_o    <= '0;
      sof_o    <= 1'b0;
      eol_o    <= 1'b0;
      eof_o    <= 1'b0;
    end else begin
      valid_o <= valid_i;
      sof_o   <= valid_i & w_in_sof;
      eol_o   <= valid_i & w_in_eol;
      eof_o   <= valid_i & w_in_eof;
      if (valid_i) begin
        data_0_o <= data_0_i;
        data_1_o <= data_1_i;
        col_o    <= w_in_col;
        row_o    <= w_in_row;
      end
    end
  end

  // Result path.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      result_valid_o <= 1'b0;
      result_o       <= '0;
      result_col_o   <= '0;
      result_row_o   <= '0;
      frame_done_o   <= 1'b0;
      frame_count_o  <= '0;
    end else begin
      result_valid_o <= result_valid_i;
      frame_done_o   <= result_valid_i & w_res_eof;
      if (result_valid_i) begin
        result_o     <= result_i;
        result_col_o <= w_res_col;
        result_row_o <= w_res_row;
        if (w_res_eof) begin
          frame_count_o <= frame_count_o + 16'd1;
        end
      end
    end
  end

`ifdef DFDD_INF_NAN_CHECK_EN
  // An all-ones exponent field marks Inf or NaN.
  logic w_nan_hit;
  assign w_nan_hit = (valid_i & ((&data_0_i[FP_WIDTH-2 -: EXP_WIDTH]) |
                                 (&data_1_i[FP_WIDTH-2 -: EXP_WIDTH]))) |
                     (result_valid_i & (&result_i[FP_WIDTH-2 -: EXP_WIDTH]));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      nan_err_o <= 1'b0;
    end else if (w_nan_hit) begin
      nan_err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dfdd_interface.sv
// tb_dfdd_interface: randomized self-checking bench for dfdd_interface, run on
// a reduced 20x10 frame so that several full frames fit in a short run.
module tb_dfdd_interface;

  localparam int W    = 20;
  localparam int H    = 10;
  localparam int NPIX = W * H;
  localparam int CW   = $clog2(W);
  localparam int RW   = $clog2(H);

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [15:0]   data_0_i = '0;
  logic [15:0]   data_1_i = '0;
  logic          valid_o;
  logic [15:0]   data_0_o;
  logic [15:0]   data_1_o;
  logic [CW-1:0] col_o;
  logic [RW-1:0] row_o;
  logic          sof_o;
  logic          eol_o;
  logic          eof_o;
  logic          result_valid_i = 1'b0;
  logic [15:0]   result_i = '0;
  logic          result_valid_o;
  logic [15:0]   result_o;
  logic [CW-1:0] result_col_o;
  logic [RW-1:0] result_row_o;
  logic          frame_done_o;
  logic [15:0]   frame_count_o;
`ifdef DFDD_INF_NAN_CHECK_EN
  logic          nan_err_o;
`endif

  always #5 clk = ~clk;

  dfdd_interface #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .data_0_i      (data_0_i),
    .data_1_i      (data_1_i),
    .valid_o       (valid_o),
    .data_0_o      (data_0_o),
    .data_1_o      (data_1_o),
    .col_o         (col_o),
    .row_o         (row_o),
    .sof_o         (sof_o),
    .eol_o         (eol_o),
    .eof_o         (eof_o),
    .result_valid_i(result_valid_i),
    .result_i      (result_i),
    .result_valid_o(result_valid_o),
    .result_o      (result_o),
    .result_col_o  (result_col_o),
    .result_row_o  (result_row_o),
    .frame_done_o  (frame_done_o),
    .frame_count_o (frame_count_o)
`ifdef DFDD_INF_NAN_CHECK_EN
    ,
    .nan_err_o     (nan_err_o)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pixel streams are numbered by arrival index since reset.
  int          in_k = 0;
  int          res_k = 0;
  int          frames = 0;
  int          eof_seen = 0;
  int          done_seen = 0;
  logic [15:0] m_d0 = '0, m_d1 = '0, m_r = '0;
  int          m_col = 0, m_row = 0, m_rcol = 0, m_rrow = 0;
  bit          m_nan = 1'b0;

  function automatic bit is_inf_nan(input logic [15:0] x);
    return x[14:10] == 5'h1f;
  endfunction

  task automatic cycle(input bit rst_n, input bit v, input logic [15:0] d0,
                       input logic [15:0] d1, input bit rv, input logic [15:0] r);
    bit e_sof, e_eol, e_eof, e_done, e_v, e_rv;
    int p;
    @(negedge clk);
    rst_i          = rst_n;
    valid_i        = v;
    data_0_i       = d0;
    data_1_i       = d1;
    result_valid_i = rv;
    result_i       = r;
    @(posedge clk);
    #1;
    e_sof = 0; e_eol = 0; e_eof = 0; e_done = 0; e_v = 0; e_rv = 0;
    if (!rst_n) begin
      in_k = 0; res_k = 0; frames = 0;
      m_d0 = '0; m_d1 = '0; m_r = '0;
      m_col = 0; m_row = 0; m_rcol = 0; m_rrow = 0;
      m_nan = 1'b0;
    end else begin
      if (v) begin
        p     = in_k % NPIX;
        e_v   = 1;
        m_d0  = d0;
        m_d1  = d1;
        m_col = p % W;
        m_row = p / W;
        e_sof = (p == 0);
        e_eol = (m_col == W - 1);
        e_eof = (p == NPIX - 1);
        in_k++;
        if (is_inf_nan(d0) || is_inf_nan(d1)) m_nan = 1'b1;
      end
      if (rv) begin
        p      = res_k % NPIX;
        e_rv   = 1;
        m_r    = r;
        m_rcol = p % W;
        m_rrow = p / W;
        if (p == NPIX - 1) begin
          e_done = 1;
          frames++;
        end
        res_k++;
        if (is_inf_nan(r)) m_nan = 1'b1;
      end
    end
    if (eof_o === 1'b1) eof_seen++;
    if (frame_done_o === 1'b1) done_seen++;
    check("valid_o", 32'(valid_o), 32'(e_v));
    check("data_0_o", 32'(data_0_o), 32'(m_d0));
    check("data_1_o", 32'(data_1_o), 32'(m_d1));
    check("col_o", 32'(col_o), 32'(m_col));
    check("row_o", 32'(row_o), 32'(m_row));
    check("sof_o", 32'(sof_o), 32'(e_sof));
    check("eol_o", 32'(eol_o), 32'(e_eol));
    check("eof_o", 32'(eof_o), 32'(e_eof));
    check("result_valid_o", 32'(result_valid_o), 32'(e_rv));
    check("result_o", 32'(result_o), 32'(m_r));
    check("result_col_o", 32'(result_col_o), 32'(m_rcol));
    check("result_row_o", 32'(result_row_o), 32'(m_rrow));
    check("frame_done_o", 32'(frame_done_o), 32'(e_done));
    check("frame_count_o", 32'(frame_count_o), 32'(frames % 65536));
`ifdef DFDD_INF_NAN_CHECK_EN
    check("nan_err_o", 32'(nan_err_o), 32'(m_nan));
`endif
  endtask

  // Random finite FP16 value (exponent never all ones).
  function automatic logic [15:0] rnd_pix();
    return 16'($urandom) & 16'hBFFF;
  endfunction

  task automatic rand_cycles(input int n, input int pct_v, input int pct_rv);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, $urandom_range(0, 99) < pct_v, rnd_pix(), rnd_pix(),
            $urandom_range(0, 99) < pct_rv, rnd_pix());
    end
  endtask

  initial begin
    // Reset with garbage on the inputs: it must be ignored.
    cycle(1'b0, 1'b1, 16'h7C00, 16'h1234, 1'b1, 16'h4321);
    cycle(1'b0, 1'b1, 16'h5555, 16'h2222, 1'b0, 16'h0000);

    // First pixel after reset.
    cycle(1'b1, 1'b1, 16'h3C00, 16'h4000, 1'b0, 16'h0000);
    check("first_sof", 32'(sof_o), 32'd1);
    check("first_data0", 32'(data_0_o), 32'h3C00);

    // Back-to-back line and frame crossings on both paths.
    rand_cycles(2 * NPIX + 30, 100, 100);
    // Random gaps, several frames on each path.
    rand_cycles(1400, 70, 60);
    // Long gaps.
    rand_cycles(300, 10, 15);
    check("eof_total", 32'(eof_seen), 32'(in_k / NPIX));
    check("done_total", 32'(done_seen), 32'(res_k / NPIX));

    // Mid-frame reset, then restart from (0,0).
    cycle(1'b0, 1'b1, rnd_pix(), rnd_pix(), 1'b1, rnd_pix());
    cycle(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1, 16'h3333);
    check("restart_sof", 32'(sof_o), 32'd1);
    rand_cycles(NPIX + 10, 80, 90);

    // Inf/NaN detection (the flag is compared only when the port exists).
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    rand_cycles(5, 100, 100);
    cycle(1'b1, 1'b1, 16'h7E00, 16'h3C00, 1'b0, 16'h0000);
    rand_cycles(10, 50, 50);
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    rand_cycles(5, 100, 100);
    cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFC00);
    rand_cycles(5, 50, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
